sar_capture: RTL and testbench
==============================

Name: sar_capture

Overview:
- Digital receiving end of the SAR ADC macro's conversion interface: takes the asynchronous `done` strobe plus the 8-bit code, synchronises the strobe into the system clock domain and captures the code.
- Averages 2^AVG_LOG2 consecutive conversions and presents each result on a valid/ready output port.
- Reports overrun and conversion-timeout conditions via sticky flags.
- Sits between the ADC pins (code on uo_out, done on uio_out[0] of the ADC tile) and downstream digital logic.

Parameters:
- DW, 8, ADC code width.
- AVG_LOG2, 2, log2 of samples averaged per output; 0 = pass-through.
- TIMEOUT, 255, max clk cycles between detected done edges before a timeout is flagged; must be >= 1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset, synchronous, active-high.
- en, input, 1, capture enable.
- clr_flags, input, 1, single-cycle clear of sticky flags.
- adc_done, input, 1, asynchronous conversion-done strobe from ADC.
- adc_data, input, DW, ADC code; stable from adc_done rise until the next conversion.
- out_data, output, DW, averaged code.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, consumer accepts out_data.
- overrun, output, 1, sticky: completed average dropped because output still pending.
- timeout, output, 1, sticky: no done edge within TIMEOUT cycles while in ACC.
- busy, output, 1, high in state ACC.

Behaviour:
- Reset: FSM=IDLE; accumulator, sample count, timeout counter = 0; sync flops = 0; out_data=0, out_valid=0, overrun=0, timeout=0, busy=0.
- Synchroniser: adc_done -> s1 -> s2 -> s3. done_pulse = s2 & ~s3. One pulse per adc_done rising edge; level-high adc_done gives no further pulses.
- adc_data is sampled at the clk edge where done_pulse=1. No separate data sync; stability is guaranteed by the ADC.
- FSM IDLE:
  - en=1 -> ACC.
  - s1..s3 keep running in IDLE, so a done edge in flight does not produce a spurious pulse on entry.
- FSM ACC (busy=1):
  - On done_pulse: acc += code; cnt += 1; tcnt = 0.
  - Otherwise tcnt += 1.
  - When cnt reaches 2^AVG_LOG2 on that pulse, move to OUT with result = (acc + code) >> AVG_LOG2, truncated toward zero.
  - Accumulator width is DW+AVG_LOG2; no overflow is possible.
- FSM OUT (one cycle):
  - If out_valid=0, or out_valid=1 with out_ready=1 this cycle: load out_data=result, out_valid=1.
  - Else: drop result, set overrun.
  - Clear acc/cnt/tcnt; go to ACC if en=1, else IDLE.
  - A done_pulse arriving in OUT is counted as the first sample of the next block.
- Timeout: in ACC, when tcnt reaches TIMEOUT with no done_pulse: set timeout, discard acc/cnt, tcnt=0, stay in ACC. A done_pulse in the same cycle wins and timeout is not set.
- Output handshake:
  - Transfer occurs when out_valid & out_ready at a clk edge; out_valid then clears unless OUT reloads it in the same cycle.
  - out_data holds stable while out_valid=1 and out_ready=0.
- Latency: adc_done rising before edge k -> s1=1 after k, s2=1 after k+1, accumulate at k+2, OUT at k+3. out_valid=1 after edge k+3 (final sample of block).
- en=0 mid-block (ACC): next edge -> IDLE; acc/cnt/tcnt cleared; a pending out_valid/out_data is kept until handshaken.
- clr_flags=1: overrun and timeout cleared. A set event in the same cycle wins, so the flag stays 1.
- rst mid-operation: everything returns to reset values on the next edge, including a pending output.

Optional Feature:
- Macro SAR_CAPTURE_TWOS_COMP_EN.
- Defined: each captured code has its MSB inverted (offset-binary -> two's complement) before accumulation. The accumulator is signed and sign-extended; result is an arithmetic shift right (floor); out_data is two's complement.
- Undefined: codes are treated as unsigned offset-binary, with a logical shift.

Test Plan:
- AVG_LOG2=2, en=1, four adc_done pulses with codes 0x80,0x81,0x82,0x83 (macro off) -> out_data=0x81, out_valid rises 4 edges after the 4th adc_done rise; busy=1 until then.
- Same stimulus with SAR_CAPTURE_TWOS_COMP_EN -> out_data=0x01. Codes 0x7F,0x7F,0x7E,0x7E -> sum -6 -> out_data=0xFE.
- out_ready held 0, eight pulses of 0x10 -> out_data=0x10 stays, overrun=1 after the second block. clr_flags pulse -> overrun=0. out_ready=1 -> one transfer, out_valid=0.
- TIMEOUT=20: two pulses then silence -> timeout=1 exactly 20 cycles after the last pulse, partial sum discarded. Four further pulses of 0x40 -> out_data=0x40.
- adc_done held high 100 cycles -> exactly one sample counted. en dropped after 2 samples -> IDLE, no output. en re-raised + 4 samples -> correct average.
- rst asserted while out_valid=1 and in ACC with cnt=3 -> next edge all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/sar_capture_if.sv
// Result port of sar_capture: averaged code with a valid/ready handshake.
// The capture block drives the master side; downstream logic takes the slave side.
interface sar_capture_if #(
    parameter int DW = 8
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sar_capture.sv
// SAR ADC receive end: synchronises the done strobe, averages 2^AVG_LOG2 codes and flags overrun/timeout.
// Define SAR_CAPTURE_TWOS_COMP_EN to treat codes as offset-binary and output signed two's-complement averages.
module sar_capture #(
    parameter int DW       = 8,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr_flags,
    input  logic          adc_done,
    input  logic [DW-1:0] adc_data,
    sar_capture_if.master out_if,
    output logic          overrun,
    output logic          timeout,
    output logic          busy
);
    localparam int AW     = DW + AVG_LOG2;
    localparam int CW     = AVG_LOG2 + 1;
    localparam int N      = 1 << AVG_LOG2;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam int SYNC_N = 3;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [TW-1:0] TCNT_LIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t              state_reg;
    logic [SYNC_N-1:0]   sync_reg;
    logic [AW-1:0]       acc_reg;
    logic [CW-1:0]       cnt_reg;
    logic [TW-1:0]       tcnt_reg;
    logic [DW-1:0]       result_reg;

    logic                done_pulse;
    logic [AW-1:0]       code_ext;
    logic [AW-1:0]       base_acc;
    logic [CW-1:0]       base_cnt;
    logic [AW-1:0]       sum;
    logic [DW-1:0]       avg;
    logic                block_full;

    // Three-flop chain; the third stage only serves edge detection.
    generate
        for (genvar gi = 0; gi < SYNC_N; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= adc_done;
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign done_pulse = sync_reg[1] & ~sync_reg[2];

`ifdef SAR_CAPTURE_TWOS_COMP_EN
    logic [DW-1:0] code_tc;
    assign code_tc  = {~adc_data[DW-1], adc_data[DW-2:0]};
    assign code_ext = AW'($signed(code_tc));
    assign avg      = DW'($signed(sum) >>> AVG_LOG2);
`else
    assign code_ext = AW'(adc_data);
    assign avg      = DW'(sum >> AVG_LOG2);
`endif

    // In OUT the running sum is already cleared, so a pulse there starts a fresh block.
    assign base_acc   = (state_reg == ACC) ? acc_reg : '0;
    assign base_cnt   = (state_reg == ACC) ? cnt_reg : '0;
    assign sum        = base_acc + code_ext;
    assign block_full = (base_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            cnt_reg          <= '0;
            tcnt_reg         <= '0;
            result_reg       <= '0;
            out_if.out_data  <= '0;
            out_if.out_valid <= 1'b0;
            overrun          <= 1'b0;
            timeout          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            if (out_if.out_valid && out_if.out_ready)
                out_if.out_valid <= 1'b0;
            // Set events below are later in the block and override this clear.
            if (clr_flags) begin
                overrun <= 1'b0;
                timeout <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    acc_reg  <= '0;
                    cnt_reg  <= '0;
                    tcnt_reg <= '0;
                    if (en) begin
                        state_reg <= ACC;
                        busy      <= 1'b1;
                    end
                end

                ACC: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        tcnt_reg  <= '0;
                    end else if (done_pulse) begin
                        tcnt_reg <= '0;
                        if (block_full) begin
                            result_reg <= avg;
                            state_reg  <= OUT;
                            busy       <= 1'b0;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                        end else begin
                            acc_reg <= sum;
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end else if (tcnt_reg == TCNT_LIM) begin
                        timeout  <= 1'b1;
                        acc_reg  <= '0;
                        cnt_reg  <= '0;
                        tcnt_reg <= '0;
                    end else begin
                        tcnt_reg <= tcnt_reg + TW'(1);
                    end
                end

                OUT: begin
                    if (!out_if.out_valid || out_if.out_ready) begin
                        out_if.out_data  <= result_reg;
                        out_if.out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    tcnt_reg <= '0;
                    if (en && done_pulse && block_full) begin
                        // Only reachable in pass-through mode: one sample is a whole block.
                        result_reg <= avg;
                        state_reg  <= OUT;
                        busy       <= 1'b0;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                    end else if (en) begin
                        state_reg <= ACC;
                        busy      <= 1'b1;
                        acc_reg   <= done_pulse ? sum : '0;
                        cnt_reg   <= done_pulse ? CW'(1) : '0;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sar_capture.sv
// Directed bench for sar_capture (DW=8, AVG_LOG2=2, TIMEOUT=20); expectations follow SAR_CAPTURE_TWOS_COMP_EN.
module tb_sar_capture;
    logic       clk;
    logic       rst;
    logic       en;
    logic       clr_flags;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       overrun;
    logic       timeout;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    sar_capture_if #(.DW(8)) out_if ();

    sar_capture #(
        .DW       (8),
        .AVG_LOG2 (2),
        .TIMEOUT  (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_flags (clr_flags),
        .adc_done  (adc_done),
        .adc_data  (adc_data),
        .out_if    (out_if.master),
        .overrun   (overrun),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] c0, c1, c2, c3;
        logic [7:0] exp_u;
        logic [7:0] exp_s;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [7:0] pick(input logic [7:0] eu, input logic [7:0] es);
`ifdef SAR_CAPTURE_TWOS_COMP_EN
        return es;
`else
        return eu;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req)
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        else
            n_pass++;
    endtask

    // One conversion: done high 3 cycles (sampled 2 edges after rise), then low 3 cycles.
    task automatic conv(input logic [7:0] code);
        adc_data = code;
        adc_done = 1'b1;
        repeat (3) tick();
        adc_done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b0;
        clr_flags = 1'b0;
        adc_done  = 1'b0;
        adc_data  = 8'h00;
        out_if.out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic handshake();
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{c0: 8'h80, c1: 8'h81, c2: 8'h82, c3: 8'h83, exp_u: 8'h81, exp_s: 8'h01};
        vecs[1] = '{c0: 8'h7F, c1: 8'h7F, c2: 8'h7E, c3: 8'h7E, exp_u: 8'h7E, exp_s: 8'hFE};
        vecs[2] = '{c0: 8'h00, c1: 8'h00, c2: 8'h00, c3: 8'h03, exp_u: 8'h00, exp_s: 8'h80};
        vecs[3] = '{c0: 8'hFF, c1: 8'hFF, c2: 8'hFF, c3: 8'hFF, exp_u: 8'hFF, exp_s: 8'h7F};
        vecs[4] = '{c0: 8'h10, c1: 8'h20, c2: 8'h30, c3: 8'h41, exp_u: 8'h28, exp_s: 8'hA8};

        // Reset state
        do_reset();
        check("rst_out_data", 32'(out_if.out_data), 32'h0);
        check("rst_out_valid", 32'(out_if.out_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Latency: out_valid rises on the 4th edge after the final done rise
        en = 1'b1;
        tick();
        conv(8'h80);
        conv(8'h81);
        conv(8'h82);
        adc_data = 8'h83;
        adc_done = 1'b1;
        tick();
        tick();
        check("lat_busy_k1", 32'(busy), 32'h1);
        check("lat_valid_k1", 32'(out_if.out_valid), 32'h0);
        tick();
        check("lat_valid_k2", 32'(out_if.out_valid), 32'h0);
        tick();
        check("lat_valid_k3", 32'(out_if.out_valid), 32'h1);
        check("lat_data_k3", 32'(out_if.out_data), 32'(pick(8'h81, 8'h01)));
        adc_done = 1'b0;
        repeat (2) tick();
        handshake();
        check("lat_valid_after_xfer", 32'(out_if.out_valid), 32'h0);

        // Table of averaging vectors
        for (int i = 0; i < 5; i++) begin
            conv(vecs[i].c0);
            conv(vecs[i].c1);
            conv(vecs[i].c2);
            conv(vecs[i].c3);
            $display("vec %0d: out_valid=%0b out_data=0x%02h", i, out_if.out_valid, out_if.out_data);
            check($sformatf("vec%0d_valid", i), 32'(out_if.out_valid), 32'h1);
            check($sformatf("vec%0d_data", i), 32'(out_if.out_data), 32'(pick(vecs[i].exp_u, vecs[i].exp_s)));
            handshake();
            check($sformatf("vec%0d_xfer", i), 32'(out_if.out_valid), 32'h0);
        end
        check("vec_no_timeout", 32'(timeout), 32'h0);
        check("vec_no_overrun", 32'(overrun), 32'h0);

        // Overrun: consumer stalled across two blocks
        do_reset();
        en = 1'b1;
        tick();
        repeat (4) conv(8'h10);
        check("ovr_first_valid", 32'(out_if.out_valid), 32'h1);
        check("ovr_first_flag", 32'(overrun), 32'h0);
        repeat (4) conv(8'h10);
        $display("overrun: overrun=%0b out_data=0x%02h", overrun, out_if.out_data);
        check("ovr_flag_set", 32'(overrun), 32'h1);
        check("ovr_data_held", 32'(out_if.out_data), 32'(pick(8'h10, 8'h90)));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);
        handshake();
        check("ovr_xfer_valid", 32'(out_if.out_valid), 32'h0);

        // Timeout: 20 cycles of silence after the last sample, partial sum dropped
        do_reset();
        en = 1'b1;
        tick();
        conv(8'hF0);
        conv(8'hF0);
        repeat (16) tick();
        check("tmo_not_yet", 32'(timeout), 32'h0);
        tick();
        check("tmo_set", 32'(timeout), 32'h1);
        repeat (4) conv(8'h40);
        $display("timeout: timeout=%0b out_data=0x%02h", timeout, out_if.out_data);
        check("tmo_block_valid", 32'(out_if.out_valid), 32'h1);
        check("tmo_block_data", 32'(out_if.out_data), 32'(pick(8'h40, 8'hC0)));
        check("tmo_sticky", 32'(timeout), 32'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("tmo_cleared", 32'(timeout), 32'h0);

        // Level-high done counts once (held below the timeout window)
        do_reset();
        en = 1'b1;
        tick();
        adc_data = 8'h20;
        adc_done = 1'b1;
        repeat (12) tick();
        adc_done = 1'b0;
        repeat (2) tick();
        conv(8'h40);
        conv(8'h40);
        check("lvl_no_early_out", 32'(out_if.out_valid), 32'h0);
        conv(8'h40);
        check("lvl_valid", 32'(out_if.out_valid), 32'h1);
        check("lvl_data", 32'(out_if.out_data), 32'(pick(8'h38, 8'hB8)));

        // en dropped mid-block discards the partial sum
        do_reset();
        en = 1'b1;
        tick();
        conv(8'h80);
        conv(8'h80);
        en = 1'b0;
        tick();
        check("en_drop_busy", 32'(busy), 32'h0);
        tick();
        check("en_drop_no_out", 32'(out_if.out_valid), 32'h0);
        en = 1'b1;
        tick();
        repeat (4) conv(8'h10);
        check("en_restart_valid", 32'(out_if.out_valid), 32'h1);
        check("en_restart_data", 32'(out_if.out_data), 32'(pick(8'h10, 8'h90)));

        // Reset with a pending output and a 3/4-full block
        do_reset();
        en = 1'b1;
        tick();
        repeat (4) conv(8'h55);
        check("mid_pending", 32'(out_if.out_valid), 32'h1);
        repeat (3) conv(8'h55);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_if.out_valid), 32'h0);
        check("mid_rst_data", 32'(out_if.out_data), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
